seq_det_prog: RTL and testbench
===============================

// Module: seq_det_prog
// PURPOSE
//  Runtime-programmable serial sequence detector (Mealy, registered output) for 1..MAX_LEN-bit patterns.
//  Supersedes the fixed 4-bit detectors (1010/1101/1001/1011); overlap vs non-overlap is a runtime select.
//  Adds an input-valid qualifier, a saturating match counter and config-error flagging.
//  Sits on a serial bit stream feeding pattern-triggered control/status logic.
// PARAMETERS
//  MAX_LEN      8           max pattern length in bits (>=2)
//  CNT_W        16          match_cnt width
//  DEF_PATTERN  8'b0000_1011  pattern loaded at reset (LSB-aligned)
//  DEF_LEN      4           pattern length loaded at reset
//  DEF_OVERLAP  1           overlap mode loaded at reset
// PORTS
//  clk          in   1         clock, all logic on posedge
//  rst          in   1         synchronous, active-high reset
//  cfg_load     in   1         latch cfg_* this cycle
//  cfg_pattern  in   MAX_LEN   pattern; bit[len-1] is received first, bit[0] last
//  cfg_len      in   LEN_W     pattern length, LEN_W=$clog2(MAX_LEN+1)
//  cfg_overlap  in   1         1=overlapping, 0=non-overlapping detection
//  din_valid    in   1         din is sampled only when high
//  din          in   1         serial data bit
//  cnt_clr      in   1         clear match_cnt
//  dout         out  1         1-cycle match pulse, registered
//  match_cnt    out  CNT_W     saturating count of matches
//  cfg_err      out  1         active config invalid (len==0 or len>MAX_LEN); detector disabled
// BEHAVIOUR
//  Reset: pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, hist=0, fill=0, dout=0, match_cnt=0, cfg_err=0.
//  Accepted bit: din_valid=1, no cfg_load, no rst. hist<={hist[MAX_LEN-2:0],din}; fill=min(fill+1,len).
//  Match (comb): accepted bit && !cfg_err && fill+1>=len && ({hist,din} & mask)==(pattern & mask), mask=(1<<len)-1.
//  dout <= match at the same edge; high exactly one cycle after the completing bit is presented, else 0.
//  Overlap=1: fill is unchanged after a match; suffix bits are reused (1011 on 1011011 -> 2 matches).
//  Overlap=0: on match, fill<=0; the next match needs len fresh bits (1011011 -> 1 match).
//  din_valid=0: hist, fill hold; dout<=0. Gaps do not break a sequence.
//  cfg_load: latch pattern/len/overlap; hist<=0, fill<=0, dout<=0; din ignored that cycle;
//   cfg_err<=(cfg_len==0 || cfg_len>MAX_LEN). match_cnt is not affected.
//  cfg_err=1: no matches; bits still shift in; the next valid cfg_load clears cfg_err.
//  match_cnt: +1 per match; saturates at 2^CNT_W-1 (no wrap).
//   cnt_clr alone -> 0; cnt_clr with a match in the same cycle -> 1.
//  rst has priority over cfg_load and all other inputs. rst mid-sequence discards partial history.
//  len==1: every accepted bit equal to pattern[0] matches (both modes).
//  States (implicit in fill): IDLE(fill=0) -> FILLING(0<fill<len) -> ARMED(fill=len).
//   Non-overlap match: ARMED -> IDLE.
// STRUCTURE
//  Package seq_det_pkg: LEN_W computation, default constants, mask function len->MAX_LEN-bit mask.
//  Sub-module seq_match_cnt (CNT_W saturating counter with clr/inc, clr+inc -> 1).
//  Top: config regs, hist shift reg, fill counter, comparator, dout register.
// TESTING
//  1 Reset defaults, overlap=1, stream 1,0,1,1,0,1,1 (valid) -> dout high after bits 4 and 7; match_cnt=2.
//  2 cfg_load pattern=4'b1011, len=4, overlap=0; same stream -> dout only after bit 4; match_cnt=1.
//  3 cfg_load len=6, pattern=6'b110100; stream 1,1,0,1,0,0 with din_valid low 3 cycles between bits 3 and 4 -> one pulse after bit 6.
//  4 cfg_load len=0 -> cfg_err=1, no dout on any stream; reload len=3 pattern=3'b101 -> cfg_err=0, detects 101.
//  5 CNT_W=2: 5 matches -> match_cnt holds 3; cnt_clr with a concurrent match -> 1; cnt_clr alone -> 0.
//  6 rst after bits 1,0,1 of 1011, then bit 1 -> no dout; cfg_load mid-sequence -> history cleared, no stale match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: default configuration constants, pattern-length width calculation,
// and a length -> LSB-aligned bit-mask helper.
package seq_det_pkg;

   localparam int unsigned PKG_MAX_LEN     = 8;
   localparam int unsigned PKG_CNT_W       = 16;
   localparam logic [31:0] PKG_DEF_PATTERN = 32'h0000_000B;
   localparam int unsigned PKG_DEF_LEN     = 4;
   localparam bit          PKG_DEF_OVERLAP = 1'b1;

   // Widest mask the helper can produce; callers truncate to their pattern width.
   localparam int unsigned MASK_W = 32;

   // Bits needed to hold a length in 0..max_len.
   function automatic int unsigned calc_len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

   // Mask with the low 'len' bits set.
   function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MASK_W; i++) begin
         m[i] = (i < len);
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with clear; clear and increment together yield 1.
// Latency: count updates on the clock edge after i_inc/i_clr are presented.
// Backpressure: none; i_inc is a single-cycle pulse, never stalled.
//
// Ports: clk/rst (sync, active-high), i_clr clear request, i_inc increment
// request, o_cnt current count (holds at all-ones).
module seq_match_cnt #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         // A match landing on the clear cycle is counted, not lost.
         r_cnt <= i_inc ? CNT_W'(1) : '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial sequence detector (Mealy match, registered pulse).
// Latency: o_dout pulses one cycle after the completing bit is presented.
// Backpressure: none; i_din_valid low simply holds state (gaps do not break a sequence).
//
// Ports: clk/rst (sync, active-high); i_cfg_load latches i_cfg_pattern (bit[len-1]
// received first), i_cfg_len, i_cfg_overlap; i_din_valid/i_din serial input;
// i_cnt_clr clears o_match_cnt; o_dout match pulse; o_match_cnt saturating count;
// o_cfg_err flags an invalid active length (detector disabled until a good load).
module seq_det_prog
   import seq_det_pkg::*;
#(
   parameter int unsigned          MAX_LEN     = PKG_MAX_LEN,
   parameter int unsigned          CNT_W       = PKG_CNT_W,
   parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(PKG_DEF_PATTERN),
   parameter int unsigned          DEF_LEN     = PKG_DEF_LEN,
   parameter bit                   DEF_OVERLAP = PKG_DEF_OVERLAP,
   localparam int unsigned         LEN_W       = calc_len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_cfg_load,
   input  logic [MAX_LEN-1:0] i_cfg_pattern,
   input  logic [LEN_W-1:0]   i_cfg_len,
   input  logic               i_cfg_overlap,
   input  logic               i_din_valid,
   input  logic               i_din,
   input  logic               i_cnt_clr,
   output logic               o_dout,
   output logic [CNT_W-1:0]   o_match_cnt,
   output logic               o_cfg_err
);

   logic [MAX_LEN-1:0] r_pattern;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;
   logic               r_cfg_err;
   // Only MAX_LEN-1 past bits are needed: the current bit completes the window.
   logic [MAX_LEN-2:0] r_hist;
   // Fresh bits available toward a match, capped at r_len (IDLE=0, FILLING, ARMED=len).
   logic [LEN_W-1:0]   r_fill;
   logic               r_dout;

   logic [MAX_LEN-1:0] w_window;
   logic [MAX_LEN-1:0] w_mask;
   logic [LEN_W:0]     w_fill_inc;
   logic [LEN_W-1:0]   w_fill_next;
   logic               w_armed;
   logic               w_accept;
   logic               w_match;
   logic               w_len_bad;

   assign w_window    = {r_hist, i_din};
   assign w_mask      = MAX_LEN'(len_mask(32'(r_len)));
   assign w_fill_inc  = {1'b0, r_fill} + (LEN_W + 1)'(1);
   // The current bit counts toward the window, hence fill+1 against len.
   assign w_armed     = (w_fill_inc >= {1'b0, r_len});
   assign w_fill_next = (w_fill_inc > {1'b0, r_len}) ? r_len : w_fill_inc[LEN_W-1:0];
   assign w_accept    = i_din_valid & ~i_cfg_load;
   assign w_match     = w_accept & ~r_cfg_err & w_armed &
                        (((w_window ^ r_pattern) & w_mask) == '0);
   assign w_len_bad   = (i_cfg_len == '0) || (i_cfg_len > LEN_W'(MAX_LEN));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pattern <= DEF_PATTERN;
         r_len     <= LEN_W'(DEF_LEN);
         r_overlap <= DEF_OVERLAP;
         r_cfg_err <= 1'b0;
         r_hist    <= '0;
         r_fill    <= '0;
         r_dout    <= 1'b0;
      end else if (i_cfg_load) begin
         // New configuration starts from empty history so no old bits can match.
         r_pattern <= i_cfg_pattern;
         r_len     <= i_cfg_len;
         r_overlap <= i_cfg_overlap;
         r_cfg_err <= w_len_bad;
         r_hist    <= '0;
         r_fill    <= '0;
         r_dout    <= 1'b0;
      end else begin
         r_dout <= w_match;
         if (w_accept) begin
            r_hist <= w_window[MAX_LEN-2:0];
            // Non-overlapping: a match consumes its bits, the next needs len fresh ones.
            r_fill <= (w_match && !r_overlap) ? '0 : w_fill_next;
         end
      end
   end

   seq_match_cnt #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (i_cnt_clr),
      .i_inc (w_match),
      .o_cnt (o_match_cnt)
   );

   assign o_dout    = r_dout;
   assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: queue-based reference model checked every cycle on two
// instances (16-bit and 2-bit counters), plus hand-computed per-bit expectations.
// Inputs change at negedge / just after posedge; outputs are sampled after posedge.
module tb_seq_det_prog;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_load = 1'b0;
   logic [7:0]  cfg_pattern = '0;
   logic [3:0]  cfg_len = '0;
   logic        cfg_overlap = 1'b0;
   logic        din_valid = 1'b0;
   logic        din = 1'b0;
   logic        cnt_clr = 1'b0;

   logic        dout_a, dout_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;
   logic        err_a, err_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_det_prog u_dut (
      .clk(clk), .rst(rst), .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern),
      .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_din_valid(din_valid),
      .i_din(din), .i_cnt_clr(cnt_clr), .o_dout(dout_a), .o_match_cnt(cnt_a),
      .o_cfg_err(err_a));

   seq_det_prog #(.CNT_W(2)) u_dut_c2 (
      .clk(clk), .rst(rst), .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern),
      .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_din_valid(din_valid),
      .i_din(din), .i_cnt_clr(cnt_clr), .o_dout(dout_b), .o_match_cnt(cnt_b),
      .o_cfg_err(err_b));

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Keeps the fresh accepted bits (oldest first) and tests the newest len of them.
   bit        q[$];
   bit [7:0]  m_pattern;
   int        m_len;
   bit        m_overlap;
   bit        m_err;
   bit        m_dout;
   int        m_cnt_a;
   int        m_cnt_b;

   initial begin
      forever begin
         @(posedge clk);
         begin
            bit match;
            match = 1'b0;
            if (rst) begin
               m_pattern = 8'b0000_1011; m_len = 4; m_overlap = 1'b1; m_err = 1'b0;
               q.delete(); m_cnt_a = 0; m_cnt_b = 0;
            end else begin
               if (cfg_load) begin
                  m_pattern = cfg_pattern; m_len = int'(cfg_len); m_overlap = cfg_overlap;
                  m_err = (m_len == 0) || (m_len > 8);
                  q.delete();
               end else if (din_valid) begin
                  q.push_back(din);
                  if (q.size() > 8) void'(q.pop_front());
                  if (!m_err && q.size() >= m_len) begin
                     match = 1'b1;
                     for (int k = 0; k < m_len; k++)
                        if (q[q.size() - 1 - k] != m_pattern[k]) match = 1'b0;
                  end
                  if (match && !m_overlap) q.delete();
               end
               if (cnt_clr) begin
                  m_cnt_a = match ? 1 : 0;
                  m_cnt_b = match ? 1 : 0;
               end else if (match) begin
                  if (m_cnt_a < 65535) m_cnt_a++;
                  if (m_cnt_b < 3) m_cnt_b++;
               end
            end
            m_dout = match;
         end
         #1;
         chk("cyc_dout",    int'(dout_a), int'(m_dout));
         chk("cyc_dout_c2", int'(dout_b), int'(m_dout));
         chk("cyc_cnt",     int'(cnt_a),  m_cnt_a);
         chk("cyc_cnt_c2",  int'(cnt_b),  m_cnt_b);
         chk("cyc_err",     int'(err_a),  int'(m_err));
         chk("cyc_err_c2",  int'(err_b),  int'(m_err));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input bit v, input bit d, input bit ld, input bit clr, input bit r);
      @(negedge clk);
      din_valid = v; din = d; cfg_load = ld; cnt_clr = clr; rst = r;
      @(posedge clk);
      #2;
      din_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; rst = 1'b0;
   endtask

   task automatic load(input bit [7:0] pat, input bit [3:0] len, input bit ov);
      cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // Sends n bits MSB-first; returns dout seen after each bit in the same order.
   task automatic send(input bit [15:0] bits, input int n, output bit [15:0] seen);
      seen = '0;
      for (int i = 0; i < n; i++) begin
         step(1'b1, bits[n - 1 - i], 1'b0, 1'b0, 1'b0);
         seen[n - 1 - i] = dout_a;
      end
   endtask

   bit [15:0] seen;

   initial begin
      // Watchdog: the run is short; reaching this means something hung.
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      // reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2; rst = 1'b0;
      chk("rst_dout", int'(dout_a), 0);
      chk("rst_cnt",  int'(cnt_a),  0);
      chk("rst_err",  int'(err_a),  0);

      // 1: defaults 1011 overlapping
      send(16'b1011011, 7, seen);
      chk("t1_dout_seq", int'(seen), 'b0001001);
      chk("t1_cnt", int'(cnt_a), 2);

      // 2: non-overlapping
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      load(8'b0000_1011, 4'd4, 1'b0);
      send(16'b1011011, 7, seen);
      chk("t2_dout_seq", int'(seen), 'b0001000);
      chk("t2_cnt", int'(cnt_a), 1);

      // 3: len 6 with a valid gap
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      load(8'b0011_0100, 4'd6, 1'b1);
      send(16'b110, 3, seen);
      chk("t3_dout_a", int'(seen), 0);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_gap_dout", int'(dout_a), 0);
      send(16'b100, 3, seen);
      chk("t3_dout_b", int'(seen), 'b001);
      chk("t3_cnt", int'(cnt_a), 1);

      // 4: config errors, then a good reload
      load(8'b0000_0101, 4'd0, 1'b1);
      chk("t4_err_len0", int'(err_a), 1);
      send(16'b1011011, 7, seen);
      chk("t4_err_nodout", int'(seen), 0);
      load(8'b0000_0101, 4'd9, 1'b1);
      chk("t4_err_len9", int'(err_a), 1);
      load(8'b0000_0101, 4'd3, 1'b1);
      chk("t4_err_clear", int'(err_a), 0);
      send(16'b10101, 5, seen);
      chk("t4_dout_seq", int'(seen), 'b00101);

      // 5: saturation on the 2-bit counter, clear interplay
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send(16'b10101010101, 11, seen);
      chk("t5_dout_seq", int'(seen), 'b00101010101);
      chk("t5_cnt16", int'(cnt_a), 5);
      chk("t5_cnt2_sat", int'(cnt_b), 3);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t5_clr_match_dout", int'(dout_a), 1);
      chk("t5_clr_match_cnt2", int'(cnt_b), 1);
      chk("t5_clr_match_cnt16", int'(cnt_a), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_clr_alone", int'(cnt_b), 0);

      // 6: reset and reload mid-sequence discard history
      load(8'b0000_1011, 4'd4, 1'b1);
      send(16'b101, 3, seen);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send(16'b1, 1, seen);
      chk("t6_rst_nostale", int'(seen), 0);
      send(16'b101, 3, seen);
      load(8'b0000_1011, 4'd4, 1'b1);
      send(16'b1, 1, seen);
      chk("t6_load_nostale", int'(seen), 0);
      send(16'b011, 3, seen);
      chk("t6_fresh_match", int'(seen), 'b001);

      repeat (2) @(posedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
